// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with valid/ready input and an auto-scan mode.
// Optional macro DEC_ACTIVE_LOW_EN selects one-cold output polarity (inactive = all ones).
module decoder_nto2n_seq #(
  parameter int N        = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [N-1:0]          a,
  input  logic                  a_valid,
  output logic                  a_ready,
  output logic [(1<<N)-1:0]     y,
  output logic                  y_valid,
  output logic [N-1:0]          scan_idx
);

  localparam int OUT_W = 1 << N;
  localparam logic [15:0] DIV_M1 = 16'(SCAN_DIV - 1);

`ifdef DEC_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0] Y_OFF = {OUT_W{1'b1}};
`else
  localparam logic [OUT_W-1:0] Y_OFF = {OUT_W{1'b0}};
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t           r_state;
  logic [OUT_W-1:0] r_y;
  logic             r_y_valid;
  logic [N-1:0]     r_idx;
  logic [15:0]      r_cnt;
  logic             w_accept;
  logic [N-1:0]     w_idx_next;

  // Selected-line pattern for a code, already in output polarity.
  function automatic logic [OUT_W-1:0] sel_code(input logic [N-1:0] idx);
    logic [OUT_W-1:0] hot;
    hot = {{(OUT_W-1){1'b0}}, 1'b1} << idx;
`ifdef DEC_ACTIVE_LOW_EN
    return ~hot;
`else
    return hot;
`endif
  endfunction

  assign a_ready    = en & ~mode & rst_n;
  assign w_accept   = a_valid & a_ready;
  assign w_idx_next = r_idx + N'(1);

  assign y        = r_y;
  assign y_valid  = r_y_valid;
  assign scan_idx = r_idx;

  // Control FSM with all outputs registered; en=0 dominates, then mode picks DECODE or SCAN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_y       <= Y_OFF;
      r_y_valid <= 1'b0;
      r_idx     <= {N{1'b0}};
      r_cnt     <= 16'd0;
    end else if (!en) begin
      r_state   <= ST_IDLE;
      r_y       <= Y_OFF;
      r_y_valid <= 1'b0;
      r_idx     <= {N{1'b0}};
      r_cnt     <= 16'd0;
    end else if (!mode) begin
      r_state <= ST_DECODE;
      r_idx   <= {N{1'b0}};
      r_cnt   <= 16'd0;
      if (w_accept) begin
        r_y       <= sel_code(a);
        r_y_valid <= 1'b1;
      end else if (r_state != ST_DECODE) begin
        // Fresh entry into decode shows nothing until the first accept.
        r_y       <= Y_OFF;
        r_y_valid <= 1'b0;
      end else begin
        r_y       <= r_y;
        r_y_valid <= 1'b0;
      end
    end else begin
      r_state <= ST_SCAN;
      case (r_state)
        ST_SCAN: begin
          if (r_cnt == DIV_M1) begin
            r_cnt     <= 16'd0;
            r_idx     <= w_idx_next;
            r_y       <= sel_code(w_idx_next);
            r_y_valid <= 1'b1;
          end else begin
            r_cnt     <= r_cnt + 16'd1;
            r_idx     <= r_idx;
            r_y       <= r_y;
            r_y_valid <= 1'b0;
          end
        end
        default: begin
          r_cnt     <= 16'd0;
          r_idx     <= {N{1'b0}};
          r_y       <= sel_code({N{1'b0}});
          r_y_valid <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Directed self-checking bench for decoder_nto2n_seq (N=2/SCAN_DIV=3 and N=3/SCAN_DIV=1 instances).
// Expectations follow DEC_ACTIVE_LOW_EN when the bundle is compiled with it.
module tb_decoder_nto2n_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en2, mode2, av2, ar2, yv2;
  logic [1:0] a2, si2;
  logic [3:0] y2;
  logic       en3, mode3, av3, ar3, yv3;
  logic [2:0] a3, si3;
  logic [7:0] y3;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  decoder_nto2n_seq #(.N(2), .SCAN_DIV(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .mode(mode2), .a(a2), .a_valid(av2),
    .a_ready(ar2), .y(y2), .y_valid(yv2), .scan_idx(si2)
  );

  decoder_nto2n_seq #(.N(3), .SCAN_DIV(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .mode(mode3), .a(a3), .a_valid(av3),
    .a_ready(ar3), .y(y3), .y_valid(yv3), .scan_idx(si3)
  );

  function automatic logic [3:0] pol4(input logic [3:0] x);
`ifdef DEC_ACTIVE_LOW_EN
    return ~x;
`else
    return x;
`endif
  endfunction

  function automatic logic [7:0] pol8(input logic [7:0] x);
`ifdef DEC_ACTIVE_LOW_EN
    return ~x;
`else
    return x;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_vec++; if (y2 !== pol4(4'b0000)) begin n_err++; $display("FAIL rst_y2 got=%b exp=%b", y2, pol4(4'b0000)); end
    n_vec++; if (yv2 !== 1'b0) begin n_err++; $display("FAIL rst_yv2 got=%b exp=0", yv2); end
    n_vec++; if (ar2 !== 1'b0) begin n_err++; $display("FAIL rst_ar2 got=%b exp=0", ar2); end
    n_vec++; if (si2 !== 2'd0) begin n_err++; $display("FAIL rst_si2 got=%0d exp=0", si2); end
    n_vec++; if (y3 !== pol8(8'h00)) begin n_err++; $display("FAIL rst_y3 got=%b exp=%b", y3, pol8(8'h00)); end
    step();
    rst_n = 1'b1;
    step();
    n_vec++; if (y2 !== pol4(4'b0000)) begin n_err++; $display("FAIL rel_y2 got=%b exp=%b", y2, pol4(4'b0000)); end
    n_vec++; if (yv2 !== 1'b0) begin n_err++; $display("FAIL rel_yv2 got=%b exp=0", yv2); end
    n_vec++; if (ar2 !== 1'b0) begin n_err++; $display("FAIL rel_ar2 got=%b exp=0", ar2); end
    en2 = 1'b1;
    #1;
    n_vec++; if (ar2 !== 1'b1) begin n_err++; $display("FAIL en_ar2 got=%b exp=1", ar2); end
  endtask

  task automatic test_decode();
    logic [3:0] exp;
    for (int i = 0; i < 4; i++) begin
      a2 = 2'(i); av2 = 1'b1;
      step();
      exp = 4'(1 << i);
      n_vec++; if (y2 !== pol4(exp)) begin n_err++; $display("FAIL dec_y a=%0d got=%b exp=%b", i, y2, pol4(exp)); end
      n_vec++; if (yv2 !== 1'b1) begin n_err++; $display("FAIL dec_yv a=%0d got=%b exp=1", i, yv2); end
    end
    av2 = 1'b0; a2 = 2'd1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_vec++; if (y2 !== pol4(4'b1000)) begin n_err++; $display("FAIL hold_y got=%b exp=%b", y2, pol4(4'b1000)); end
      n_vec++; if (yv2 !== 1'b0) begin n_err++; $display("FAIL hold_yv got=%b exp=0", yv2); end
    end
  endtask

  task automatic test_scan();
    logic [3:0] exp;
    mode2 = 1'b1; av2 = 1'b1; a2 = 2'd2;
    #1;
    n_vec++; if (ar2 !== 1'b0) begin n_err++; $display("FAIL scan_ar_comb got=%b exp=0", ar2); end
    for (int c = 0; c < 14; c++) begin
      step();
      exp = 4'(1 << ((c / 3) % 4));
      n_vec++; if (y2 !== pol4(exp)) begin n_err++; $display("FAIL scan_y c=%0d got=%b exp=%b", c, y2, pol4(exp)); end
      n_vec++; if (yv2 !== (c % 3 == 0)) begin n_err++; $display("FAIL scan_yv c=%0d got=%b exp=%b", c, yv2, (c % 3 == 0)); end
      n_vec++; if (si2 !== 2'((c / 3) % 4)) begin n_err++; $display("FAIL scan_idx c=%0d got=%0d exp=%0d", c, si2, (c / 3) % 4); end
      n_vec++; if (ar2 !== 1'b0) begin n_err++; $display("FAIL scan_ar c=%0d got=%b exp=0", c, ar2); end
    end
    av2 = 1'b0;
  endtask

  task automatic test_mode_switch();
    logic [3:0] exp;
    mode2 = 1'b0; a2 = 2'd2; av2 = 1'b1;
    step();
    n_vec++; if (y2 !== pol4(4'b0100)) begin n_err++; $display("FAIL ms_dec got=%b exp=%b", y2, pol4(4'b0100)); end
    mode2 = 1'b1; av2 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      exp = 4'(1 << (c / 3));
      n_vec++; if (y2 !== pol4(exp)) begin n_err++; $display("FAIL ms_scan c=%0d got=%b exp=%b", c, y2, pol4(exp)); end
    end
    mode2 = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      n_vec++; if (y2 !== pol4(4'b0000)) begin n_err++; $display("FAIL ms_back c=%0d got=%b exp=%b", c, y2, pol4(4'b0000)); end
      n_vec++; if (yv2 !== 1'b0) begin n_err++; $display("FAIL ms_back_yv c=%0d got=%b exp=0", c, yv2); end
    end
    a2 = 2'd1; av2 = 1'b1;
    step();
    av2 = 1'b0;
    n_vec++; if (y2 !== pol4(4'b0010)) begin n_err++; $display("FAIL ms_acc got=%b exp=%b", y2, pol4(4'b0010)); end
    n_vec++; if (yv2 !== 1'b1) begin n_err++; $display("FAIL ms_acc_yv got=%b exp=1", yv2); end
    mode2 = 1'b1;
    repeat (4) step();
    n_vec++; if (si2 !== 2'd1) begin n_err++; $display("FAIL en_pre_idx got=%0d exp=1", si2); end
    en2 = 1'b0;
    step();
    n_vec++; if (y2 !== pol4(4'b0000)) begin n_err++; $display("FAIL en_off_y got=%b exp=%b", y2, pol4(4'b0000)); end
    n_vec++; if (yv2 !== 1'b0) begin n_err++; $display("FAIL en_off_yv got=%b exp=0", yv2); end
    n_vec++; if (si2 !== 2'd0) begin n_err++; $display("FAIL en_off_idx got=%0d exp=0", si2); end
    en2 = 1'b1;
    step();
    n_vec++; if (y2 !== pol4(4'b0001)) begin n_err++; $display("FAIL en_on_y got=%b exp=%b", y2, pol4(4'b0001)); end
    n_vec++; if (yv2 !== 1'b1) begin n_err++; $display("FAIL en_on_yv got=%b exp=1", yv2); end
    n_vec++; if (si2 !== 2'd0) begin n_err++; $display("FAIL en_on_idx got=%0d exp=0", si2); end
  endtask

  task automatic test_scan_div1();
    logic [7:0] exp;
    en3 = 1'b1; mode3 = 1'b1;
    for (int c = 0; c < 9; c++) begin
      step();
      exp = 8'(1 << (c % 8));
      n_vec++; if (y3 !== pol8(exp)) begin n_err++; $display("FAIL d1_y c=%0d got=%b exp=%b", c, y3, pol8(exp)); end
      n_vec++; if (yv3 !== 1'b1) begin n_err++; $display("FAIL d1_yv c=%0d got=%b exp=1", c, yv3); end
      n_vec++; if (si3 !== 3'(c % 8)) begin n_err++; $display("FAIL d1_idx c=%0d got=%0d exp=%0d", c, si3, c % 8); end
    end
  endtask

  task automatic test_async_reset();
    mode2 = 1'b0; a2 = 2'd2; av2 = 1'b1;
    step();
    av2 = 1'b0;
    n_vec++; if (y2 !== pol4(4'b0100)) begin n_err++; $display("FAIL ar_pre got=%b exp=%b", y2, pol4(4'b0100)); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (y2 !== pol4(4'b0000)) begin n_err++; $display("FAIL ar_y2 got=%b exp=%b", y2, pol4(4'b0000)); end
    n_vec++; if (yv2 !== 1'b0) begin n_err++; $display("FAIL ar_yv2 got=%b exp=0", yv2); end
    n_vec++; if (ar2 !== 1'b0) begin n_err++; $display("FAIL ar_ar2 got=%b exp=0", ar2); end
    n_vec++; if (y3 !== pol8(8'h00)) begin n_err++; $display("FAIL ar_y3 got=%b exp=%b", y3, pol8(8'h00)); end
    n_vec++; if (si3 !== 3'd0) begin n_err++; $display("FAIL ar_si3 got=%0d exp=0", si3); end
    n_vec++; if (yv3 !== 1'b0) begin n_err++; $display("FAIL ar_yv3 got=%b exp=0", yv3); end
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en2 = 1'b0; mode2 = 1'b0; a2 = 2'd0; av2 = 1'b0;
    en3 = 1'b0; mode3 = 1'b0; a3 = 3'd0; av3 = 1'b0;
    test_reset();
    test_decode();
    test_scan();
    test_mode_switch();
    test_scan_div1();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decoder_nto2n_seq.md
Name: decoder_nto2n_seq

Overview:
- Registered, parametrised N-to-2^N one-hot decoder with a valid/ready input handshake.
- Adds an auto-scan mode that walks a single active output across all 2^N lines at a programmable dwell rate.
- Used for memory bank select, display digit multiplexing and refresh-row strobing; sits between control logic and bank/segment enables.

Parameters:
- N, 2, input code width; output width is 2^N (derived localparam OUT_W).
- SCAN_DIV, 4, clock cycles each output stays active in scan mode; legal range 1..65535.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  block enable; 0 forces outputs inactive
- mode  input  1  0 = decode, 1 = scan
- a  input  N  binary code to decode
- a_valid  input  1  a is valid this cycle
- a_ready  output  1  block accepts a this cycle
- y  output  OUT_W  one-hot decoded output, registered
- y_valid  output  1  one-cycle pulse when y takes a new value
- scan_idx  output  N  current scan index (binary)

Behaviour:
- Reset (rst_n low, asynchronous): y=0, y_valid=0, scan_idx=0, dwell counter=0, state IDLE. Release is synchronous to the next clk edge.
- a_ready is combinational: a_ready = en & ~mode & rst_n. It has no dependency on a_valid.
- State machine:
  - IDLE: entered on reset or en=0.
  - IDLE -> DECODE when en=1, mode=0.
  - IDLE -> SCAN when en=1, mode=1.
  - DECODE <-> SCAN on a mode change; the change takes effect at the next edge.
  - Any state -> IDLE when en=0.
- IDLE: y=0, y_valid=0, dwell counter=0, scan_idx=0.
- DECODE:
  - Accept on a_valid & a_ready. At the next edge y <= one-hot(a), i.e. y[a]=1 and all other bits 0. Latency is 1 cycle.
  - y_valid=1 for exactly the cycle following the accept.
  - y holds its last decoded value until the next accept, en=0, or a mode change.
  - Back-to-back accepts are allowed every cycle. y_valid stays high continuously while accepts are continuous, even if the same code repeats.
  - Entering DECODE from IDLE or SCAN: y=0 until the first accept.
- SCAN:
  - a and a_valid are ignored.
  - On entry, scan_idx=0, y=one-hot(0), y_valid=1 in the first SCAN cycle, dwell counter=0.
  - The dwell counter increments every cycle. When it reaches SCAN_DIV-1 it clears, scan_idx increments, y shifts to the new one-hot value, and y_valid pulses for 1 cycle.
  - Wrap: scan_idx goes from 2^N-1 to 0, and y goes from bit OUT_W-1 back to bit 0. The wrap produces a y_valid pulse.
  - SCAN_DIV=1: y advances every cycle and y_valid is held high.
- Invariant: y is always all-zero or exactly one-hot. It is never multi-hot, including on state-transition cycles.
- en=0 mid-operation: at the next edge y=0 and y_valid=0; scan progress is discarded.
- Simultaneous accept and mode=1 in the same cycle: impossible, because a_ready=0 when mode=1.
- Reset asserted mid-scan: all outputs clear immediately, without waiting for a clock edge.

Optional Feature:
- Macro DEC_ACTIVE_LOW_EN.
- Defined: y is one-cold, i.e. the selected bit is 0 and all others are 1. The inactive value, including reset and IDLE, is all ones. y_valid, a_ready and scan_idx are unchanged.
- Undefined: one-hot polarity as described in Behaviour; inactive value is all zeros.

Test Plan:
- N=2: reset held, then released with en=0 -> y=4'b0000, y_valid=0, a_ready=0. Assert rst_n low while y=4'b0100 -> y=0 immediately, before the next clk edge.
- N=2, en=1, mode=0; a=0,1,2,3 with a_valid on four consecutive cycles -> y=0001, 0010, 0100, 1000 on the four cycles following each accept; y_valid high for those 4 cycles. With a_valid=0 afterwards -> y holds 1000 and y_valid=0.
- N=2, SCAN_DIV=3, en=1, mode=1 for 14 cycles -> y sequence 0001 x3, 0010 x3, 0100 x3, 1000 x3, 0001 (wrap). y_valid pulses every 3rd cycle. a_ready=0 throughout.
- N=3, SCAN_DIV=1, scan mode -> y walks bits 0..7 and wraps to bit 0 on cycle 9; y_valid constantly 1; scan_idx 0..7 then 0.
- Decode y=0100, then mode=1 for 4 cycles, then mode=0 -> SCAN starts at 0001; on return to DECODE, y=0000 until the next accept. en=0 mid-scan -> y=0 at the next edge and scan restarts at index 0 when re-enabled.
- Compile with DEC_ACTIVE_LOW_EN, N=2 -> reset y=1111; a=2 accepted -> y=1011.
